// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix-vector control slice.
package matmul_pkg;

    localparam int DATA_W    = 14;
    localparam int ACC_W     = 28;
    localparam int N_DEFAULT = 8;

    typedef enum logic [2:0] {
        LOAD_W = 3'd0,
        LOAD_X = 3'd1,
        CLEAR  = 3'd2,
        MAC    = 3'd3,
        OUT    = 3'd4
    } state_t;

endpackage

// File: rtl/matmul_ctrl_if.sv
// Input-word and row-result handshakes between the controller and its neighbours.
// Handshake rule (both channels): a transfer happens on a rising clk edge where
// valid and ready are both 1; a producer holding valid keeps it (and its data)
// until that edge, and ready never depends on a transfer in the same cycle.
interface matmul_ctrl_if;
    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;

    // Upstream word source and downstream result sink, seen from outside.
    modport master (
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_valid
    );

    // The controller itself.
    modport slave (
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_valid
    );
endinterface

// File: rtl/matmul_counter.sv
// Up-counter with enable, synchronous clear and a terminal-count flag.
module matmul_counter #(
    parameter int W   = 3,
    parameter int MAX = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         tc
);

    // Clear (or reset) wins over enable; wrap happens only through clr.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign tc = (count == W'(MAX));

endmodule

// File: rtl/matmul_ctrl.sv
// Control sequencer for the matrix-vector datapath: loads W then X from a word
// stream, then runs N rows of N multiply-accumulates, presenting each row result.
// Optional feature: define MATMUL_CTRL_REUSE_W_EN to add the reuse_w input that
// lets a following frame skip the W load when a complete W is already resident.
module matmul_ctrl
    import matmul_pkg::*;
#(
    parameter int N   = N_DEFAULT,
    parameter int AXW = $clog2(N),
    parameter int AWW = $clog2(N*N)
) (
    input  logic           clk,
    input  logic           rst,
    matmul_ctrl_if.slave   hs,
`ifdef MATMUL_CTRL_REUSE_W_EN
    input  logic           reuse_w,
`endif
    output logic [AXW-1:0] addr_x,
    output logic           wr_en_x,
    output logic [AWW-1:0] addr_w,
    output logic           wr_en_w,
    output logic           clear_acc,
    output logic           en_acc,
    output logic [AXW-1:0] row_idx,
    output logic           busy,
    output logic           frame_done,
    output logic [2:0]     state_dbg
);

    localparam logic [2:0] ST_LOAD_W = LOAD_W;
    localparam logic [2:0] ST_LOAD_X = LOAD_X;
    localparam logic [2:0] ST_CLEAR  = CLEAR;
    localparam logic [2:0] ST_MAC    = MAC;
    localparam logic [2:0] ST_OUT    = OUT;

    logic [2:0]     state;
    logic [2:0]     state_nxt;
    logic           accept;
    logic           last_hs;

    logic           lcnt_en, lcnt_clr, lcnt_tc;
    logic [AWW-1:0] lcnt;
    logic           k_en, k_clr, k_tc;
    logic [AXW-1:0] k;
    logic           row_en, row_clr, row_tc;
    logic [AXW-1:0] row;

`ifdef MATMUL_CTRL_REUSE_W_EN
    logic           w_done;
    logic           w_loaded;
`endif

    // Load beat counter: W addresses 0..N*N-1, then X addresses 0..N-1.
    matmul_counter #(.W(AWW), .MAX(N*N-1)) u_lcnt (
        .clk(clk), .rst(rst), .en(lcnt_en), .clr(lcnt_clr), .count(lcnt), .tc(lcnt_tc)
    );

    // Column index within a row during MAC.
    matmul_counter #(.W(AXW), .MAX(N-1)) u_k (
        .clk(clk), .rst(rst), .en(k_en), .clr(k_clr), .count(k), .tc(k_tc)
    );

    // Row being computed or presented.
    matmul_counter #(.W(AXW), .MAX(N-1)) u_row (
        .clk(clk), .rst(rst), .en(row_en), .clr(row_clr), .count(row), .tc(row_tc)
    );

    assign accept = hs.in_valid && hs.in_ready;

    // Next state and counter controls.
    always_comb begin
        state_nxt = state;
        lcnt_en   = 1'b0;
        lcnt_clr  = 1'b0;
        k_en      = 1'b0;
        k_clr     = 1'b0;
        row_en    = 1'b0;
        row_clr   = 1'b0;
        last_hs   = 1'b0;
`ifdef MATMUL_CTRL_REUSE_W_EN
        w_done    = 1'b0;
`endif
        case (state)
            ST_LOAD_W: begin
                if (accept) begin
                    if (lcnt_tc) begin
                        lcnt_clr  = 1'b1;
                        state_nxt = ST_LOAD_X;
`ifdef MATMUL_CTRL_REUSE_W_EN
                        w_done    = 1'b1;
`endif
                    end else begin
                        lcnt_en = 1'b1;
                    end
                end
            end
            ST_LOAD_X: begin
                if (accept) begin
                    if (lcnt == AWW'(N-1)) begin
                        lcnt_clr  = 1'b1;
                        state_nxt = ST_CLEAR;
                    end else begin
                        lcnt_en = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                k_clr     = 1'b1;
                state_nxt = ST_MAC;
            end
            ST_MAC: begin
                if (k_tc) begin
                    k_clr     = 1'b1;
                    state_nxt = ST_OUT;
                end else begin
                    k_en = 1'b1;
                end
            end
            ST_OUT: begin
                if (hs.out_ready) begin
                    if (row_tc) begin
                        row_clr = 1'b1;
                        last_hs = 1'b1;
`ifdef MATMUL_CTRL_REUSE_W_EN
                        state_nxt = (reuse_w && w_loaded) ? ST_LOAD_X : ST_LOAD_W;
`else
                        state_nxt = ST_LOAD_W;
`endif
                    end else begin
                        row_en    = 1'b1;
                        state_nxt = ST_CLEAR;
                    end
                end
            end
            default: state_nxt = ST_LOAD_W;
        endcase
    end

    // State register; reset always restarts at the W load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_LOAD_W;
        end else begin
            state <= state_nxt;
        end
    end

`ifdef MATMUL_CTRL_REUSE_W_EN
    // Remembers that W holds a complete matrix loaded since the last reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_loaded <= 1'b0;
        end else if (w_done) begin
            w_loaded <= 1'b1;
        end
    end
`endif

    // Datapath controls and status decoded from state; everything is held at 0 in reset.
    always_comb begin
        hs.in_ready  = 1'b0;
        hs.out_valid = 1'b0;
        wr_en_w      = 1'b0;
        wr_en_x      = 1'b0;
        addr_x       = '0;
        addr_w       = '0;
        clear_acc    = 1'b0;
        en_acc       = 1'b0;
        row_idx      = '0;
        busy         = 1'b0;
        frame_done   = 1'b0;
        state_dbg    = '0;
        if (!rst) begin
            row_idx    = row;
            addr_w     = {row, {AXW{1'b0}}};
            busy       = !(state == ST_LOAD_W && lcnt == '0);
            frame_done = last_hs;
            state_dbg  = state;
            case (state)
                ST_LOAD_W: begin
                    hs.in_ready = 1'b1;
                    wr_en_w     = hs.in_valid;
                    addr_w      = lcnt;
                end
                ST_LOAD_X: begin
                    hs.in_ready = 1'b1;
                    wr_en_x     = hs.in_valid;
                    addr_x      = lcnt[AXW-1:0];
                end
                ST_CLEAR: clear_acc = 1'b1;
                ST_MAC: begin
                    en_acc = 1'b1;
                    addr_x = k;
                    addr_w = {row, k};
                end
                ST_OUT: hs.out_valid = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_ctrl.sv
// Bench for matmul_ctrl with a behavioural datapath (memories + saturating
// accumulator) and a frame-level reference model.
`timescale 1ns/1ps
module tb_matmul_ctrl;
    import matmul_pkg::*;

    localparam int N   = 8;
    localparam int NN  = N * N;
    localparam int AXW = 3;
    localparam int AWW = 6;
    localparam longint ACC_MAX = 134217727;
    localparam longint ACC_MIN = -134217728;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    matmul_ctrl_if hs();

    logic [AXW-1:0] addr_x;
    logic           wr_en_x;
    logic [AWW-1:0] addr_w;
    logic           wr_en_w;
    logic           clear_acc;
    logic           en_acc;
    logic [AXW-1:0] row_idx;
    logic           busy;
    logic           frame_done;
    logic [2:0]     state_dbg;
    logic [DATA_W-1:0] in_data;
    logic           reuse_now;
`ifdef MATMUL_CTRL_REUSE_W_EN
    logic           reuse_w = 1'b0;
    assign reuse_now = reuse_w;
`else
    assign reuse_now = 1'b0;
`endif

    matmul_ctrl #(.N(N)) dut (
        .clk(clk),
        .rst(rst),
        .hs(hs),
`ifdef MATMUL_CTRL_REUSE_W_EN
        .reuse_w(reuse_w),
`endif
        .addr_x(addr_x),
        .wr_en_x(wr_en_x),
        .addr_w(addr_w),
        .wr_en_w(wr_en_w),
        .clear_acc(clear_acc),
        .en_acc(en_acc),
        .row_idx(row_idx),
        .busy(busy),
        .frame_done(frame_done),
        .state_dbg(state_dbg)
    );

    // ---------------- behavioural datapath ----------------
    logic signed [DATA_W-1:0] xmem [N];
    logic signed [DATA_W-1:0] wmem [NN];
    logic signed [ACC_W-1:0]  acc;

    function automatic longint clamp(input longint v);
        if (v > ACC_MAX) return ACC_MAX;
        if (v < ACC_MIN) return ACC_MIN;
        return v;
    endfunction

    always @(posedge clk) begin
        longint s;
        if (wr_en_w) wmem[addr_w] <= in_data;
        if (wr_en_x) xmem[addr_x] <= in_data;
        if (clear_acc) begin
            acc <= '0;
        end else if (en_acc) begin
            s = clamp(longint'(acc) + longint'(xmem[addr_x]) * longint'(wmem[addr_w]));
            acc <= s[ACC_W-1:0];
        end
    end

    // ---------------- counters and scoreboard ----------------
    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [ACC_W-1:0] exp_q[$];
    logic [ACC_W-1:0] got_res [N];
    logic [AXW-1:0]   got_row [N];
    int n_res, n_fd, fd_cycle, n_wr_w, n_wr_x, cnt_r3;
    int cur_w [NN];
    int cur_x [N];
    int stall_en = 0;
    int stall_left = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level reference: where in the frame we are, tracked by beats and cycles.
    int m_loading, m_w_cnt, m_x_cnt, m_row, m_t, m_w_loaded;

    always @(posedge clk) begin
        if (rst) begin
            m_loading <= 1; m_w_cnt <= 0; m_x_cnt <= 0; m_row <= 0; m_t <= 0; m_w_loaded <= 0;
        end else if (m_loading != 0) begin
            if (hs.in_valid) begin
                if (m_w_cnt < NN) begin
                    m_w_cnt <= m_w_cnt + 1;
                    if (m_w_cnt == NN - 1) m_w_loaded <= 1;
                end else if (m_x_cnt == N - 1) begin
                    m_loading <= 0; m_x_cnt <= 0; m_row <= 0; m_t <= 0;
                end else begin
                    m_x_cnt <= m_x_cnt + 1;
                end
            end
        end else if (m_t < N + 1) begin
            m_t <= m_t + 1;
        end else if (hs.out_ready) begin
            if (m_row == N - 1) begin
                m_loading <= 1; m_row <= 0;
                m_w_cnt <= (reuse_now && m_w_loaded != 0) ? NN : 0;
            end else begin
                m_row <= m_row + 1; m_t <= 0;
            end
        end
    end

    logic e_ir, e_ww, e_wx, e_clr, e_en, e_ov, e_busy, e_fd;
    logic [AXW-1:0] e_ax, e_row;
    logic [AWW-1:0] e_aw;
    int kk;

    // Single compare process: every output every cycle, results on handshakes.
    always @(negedge clk) begin
        if (rst) cyc = 0; else cyc++;
        e_ir = 0; e_ww = 0; e_wx = 0; e_clr = 0; e_en = 0; e_ov = 0; e_busy = 0; e_fd = 0;
        e_ax = '0; e_aw = '0; e_row = '0;
        if (!rst) begin
            if (m_loading != 0) begin
                e_ir = 1;
                e_busy = (m_w_cnt != 0);
                if (m_w_cnt < NN) begin
                    e_ww = hs.in_valid; e_aw = AWW'(m_w_cnt);
                end else begin
                    e_wx = hs.in_valid; e_ax = AXW'(m_x_cnt);
                end
            end else begin
                e_busy = 1;
                e_row = AXW'(m_row);
                e_clr = (m_t == 0);
                e_en = (m_t >= 1 && m_t <= N);
                e_ov = (m_t == N + 1);
                kk = e_en ? m_t - 1 : 0;
                e_ax = AXW'(kk);
                e_aw = AWW'(m_row * N + kk);
                e_fd = e_ov && hs.out_ready && (m_row == N - 1);
            end
        end
        check("in_ready", hs.in_ready, e_ir);
        check("wr_en_w", wr_en_w, e_ww);
        check("wr_en_x", wr_en_x, e_wx);
        check("addr_w", addr_w, e_aw);
        check("addr_x", addr_x, e_ax);
        check("clear_acc", clear_acc, e_clr);
        check("en_acc", en_acc, e_en);
        check("out_valid", hs.out_valid, e_ov);
        check("row_idx", row_idx, e_row);
        check("busy", busy, e_busy);
        check("frame_done", frame_done, e_fd);
        if (wr_en_w) n_wr_w++;
        if (wr_en_x) n_wr_x++;
        if (frame_done) begin n_fd++; fd_cycle = cyc; end
        if (hs.out_valid && row_idx == 3) cnt_r3++;
        if (hs.out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                check("out_data", {36'd0, acc}, {36'd0, exp_q[0]});
                if (hs.out_ready) begin
                    if (n_res < N) begin
                        got_res[n_res] = acc;
                        got_row[n_res] = row_idx;
                    end
                    n_res++;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    initial begin
        hs.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (stall_en != 0 && hs.out_valid && row_idx == 3 && stall_left > 0) begin
                hs.out_ready = 1'b0;
                stall_left--;
            end else begin
                hs.out_ready = 1'b1;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic clear_stats();
        n_res = 0; n_fd = 0; fd_cycle = -1; n_wr_w = 0; n_wr_x = 0; cnt_r3 = 0;
    endtask

    task automatic push_expected();
        longint s;
        for (int r = 0; r < N; r++) begin
            s = 0;
            for (int k = 0; k < N; k++) s = clamp(s + longint'(cur_w[r*N+k]) * longint'(cur_x[k]));
            exp_q.push_back(s[ACC_W-1:0]);
        end
    endtask

    task automatic load_frame(input bit with_w, input bit gaps);
        int total;
        int v;
        int guard;
        total = with_w ? NN + N : N;
        for (int i = 0; i < total; i++) begin
            if (with_w && i < NN) v = cur_w[i];
            else if (with_w) v = cur_x[i - NN];
            else v = cur_x[i];
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    hs.in_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            hs.in_valid = 1'b1;
            in_data = DATA_W'(v);
            guard = 0;
            @(negedge clk);
            while (!hs.in_ready && guard < 50) begin @(negedge clk); guard++; end
            if (guard >= 50) begin
                check("load_accept_timeout", 0, 1);
                hs.in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        hs.in_valid = 1'b0;
    endtask

    task automatic wait_results(input string name, input int n);
        int guard = 0;
        while (n_res < n && guard < 2000) begin @(posedge clk); #1; guard++; end
        check({name, "_result_count"}, n_res, n);
        check({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int guard;
        hs.in_valid = 1'b0;
        in_data = '0;
        clear_stats();
        do_reset();

        // Identity W, X = 1..8: result r is r+1; full frame ends at cycle 152.
        for (int i = 0; i < NN; i++) cur_w[i] = (i / N == i % N) ? 1 : 0;
        for (int k = 0; k < N; k++) cur_x[k] = k + 1;
        push_expected();
        load_frame(1'b1, 1'b0);
        wait_results("t1", N);
        for (int r = 0; r < N; r++) begin
            check("t1_res", {36'd0, got_res[r]}, 64'(r + 1));
            check("t1_row", got_row[r], 64'(r));
        end
        check("t1_fd_count", n_fd, 1);
        check("t1_fd_cycle", fd_cycle, 152);

        // Signed values with random idle gaps in the load stream.
        clear_stats();
        for (int i = 0; i < NN; i++) cur_w[i] = (i % 7) - 3;
        for (int k = 0; k < N; k++) cur_x[k] = 2 * k - 5;
        push_expected();
        load_frame(1'b1, 1'b1);
        wait_results("t2", N);
        check("t2_wr_w_count", n_wr_w, NN);
        check("t2_wr_x_count", n_wr_x, N);
        check("t2_res0", {36'd0, got_res[0]}, 64'd29);
        check("t2_res1", {36'd0, got_res[1]}, 64'h0FFFFFFC);

        // Downstream stall of 5 cycles on row 3.
        clear_stats();
        for (int i = 0; i < NN; i++) cur_w[i] = i / N + 1;
        for (int k = 0; k < N; k++) cur_x[k] = 1;
        stall_en = 1; stall_left = 5;
        push_expected();
        load_frame(1'b1, 1'b0);
        wait_results("t3", N);
        stall_en = 0;
        check("t3_row3_valid_cycles", cnt_r3, 6);
        check("t3_res3", {36'd0, got_res[3]}, 64'd32);
        check("t3_res4", {36'd0, got_res[4]}, 64'd40);

        // Saturation: all operands at the positive maximum.
        clear_stats();
        for (int i = 0; i < NN; i++) cur_w[i] = 8191;
        for (int k = 0; k < N; k++) cur_x[k] = 8191;
        push_expected();
        load_frame(1'b1, 1'b0);
        wait_results("t4", N);
        for (int r = 0; r < N; r++) check("t4_sat", {36'd0, got_res[r]}, 64'd134217727);

        // Reset in the middle of MAC at row 2, k = 4, then a fresh frame.
        clear_stats();
        for (int i = 0; i < NN; i++) cur_w[i] = i % 5;
        for (int k = 0; k < N; k++) cur_x[k] = k;
        push_expected();
        load_frame(1'b1, 1'b0);
        guard = 0;
        while (!(row_idx == 2 && en_acc && addr_x == 4) && guard < 400) begin
            @(posedge clk); #1; guard++;
        end
        check("t5_reach_mac_timeout", guard < 400, 1);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_in_ready", hs.in_ready, 1);
        check("t5_en_acc", en_acc, 0);
        check("t5_out_valid", hs.out_valid, 0);
        check("t5_busy", busy, 0);
        @(posedge clk); #1;
        clear_stats();
        for (int i = 0; i < NN; i++) cur_w[i] = (i % N) + (i / N);
        for (int k = 0; k < N; k++) cur_x[k] = 1;
`ifdef MATMUL_CTRL_REUSE_W_EN
        reuse_w = 1'b1;
`endif
        push_expected();
        load_frame(1'b1, 1'b0);
        wait_results("t5", N);
        check("t5_res0", {36'd0, got_res[0]}, 64'd28);
        check("t5_res7", {36'd0, got_res[7]}, 64'd84);

`ifdef MATMUL_CTRL_REUSE_W_EN
        // Second frame reuses the resident W: only X beats are taken.
        clear_stats();
        for (int k = 0; k < N; k++) cur_x[k] = 2;
        push_expected();
        load_frame(1'b0, 1'b0);
        reuse_w = 1'b0;
        wait_results("t6", N);
        check("t6_wr_w_count", n_wr_w, 0);
        check("t6_wr_x_count", n_wr_x, N);
        check("t6_res0", {36'd0, got_res[0]}, 64'd56);
        check("t6_res7", {36'd0, got_res[7]}, 64'd168);
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Hard stop if the run stalls somewhere unexpected.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
